// File: rtl/vram_console.sv
// Text console front end: turns a byte stream into VRAM cell writes,
// with cursor tracking, hardware scroll via top_row and line/page clears.
module vram_console #(
    parameter int          COLS     = 50,
    parameter int          ROWS     = 15,
    parameter logic [7:0]  DEF_ATTR = 8'h0F
) (
    input  logic        clk_pix,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        attr_we,
    input  logic [7:0]  attr_in,
    output logic        ram_ce,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_data,
    output logic [5:0]  cursor_x,
    output logic [3:0]  cursor_y,
    output logic [3:0]  top_row,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_t;

    state_t      state_q;
    logic [5:0]  x_q;
    logic [3:0]  y_q;
    logic [3:0]  top_q;
    logic [7:0]  attr_q;
    logic        adv_q;
    logic [5:0]  col_q;
    logic        ce_q;
    logic [11:0] addr_q;
    logic [15:0] data_q;

    logic [7:0]  attr_d;
    logic [3:0]  top_d;
    logic [4:0]  row_sum;
    logic [3:0]  phys_row;
    logic [11:0] cur_addr;
    logic [11:0] line_addr;
    logic        accept;
    logic        at_bottom;
    logic        is_print;
    logic        is_cr;
    logic        is_bs;
    logic        is_lf;
    logic        is_ff;

    // A same-cycle attribute load already colours the write being launched.
    assign attr_d    = attr_we ? attr_in : attr_q;
    assign top_d     = (top_q == 4'(ROWS - 1)) ? 4'd0 : top_q + 4'd1;
    assign row_sum   = {1'b0, top_q} + {1'b0, y_q};
    assign phys_row  = (row_sum >= 5'(ROWS)) ? 4'(row_sum - 5'(ROWS))
                                             : row_sum[3:0];
    assign cur_addr  = 12'(32'(phys_row) * COLS + 32'(x_q));
    // After a scroll the freed bottom row is the old top row.
    assign line_addr = 12'(32'(top_q) * COLS);
    assign at_bottom = (y_q == 4'(ROWS - 1));

    assign accept    = in_valid && in_ready;
    assign is_print  = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign is_cr     = (in_data == 8'h0D);
    assign is_bs     = (in_data == 8'h08);
    assign is_lf     = (in_data == 8'h0A);
    assign is_ff     = (in_data == 8'h0C);

    always_ff @(posedge clk_pix or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            top_q   <= '0;
            attr_q  <= DEF_ATTR;
            adv_q   <= 1'b0;
            col_q   <= '0;
            ce_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (attr_we)
                attr_q <= attr_in;
            case (state_q)
                IDLE: begin
                    ce_q <= 1'b0;
                    if (accept) begin
                        unique case (1'b1)
                            is_print: begin
                                ce_q    <= 1'b1;
                                addr_q  <= cur_addr;
                                data_q  <= {attr_d, 1'b0, in_data[6:0]};
                                adv_q   <= 1'b1;
                                state_q <= WRITE;
                            end
                            is_cr: x_q <= '0;
                            is_bs: begin
                                if (x_q != 6'd0) begin
                                    x_q     <= x_q - 6'd1;
                                    ce_q    <= 1'b1;
                                    addr_q  <= cur_addr - 12'd1;
                                    data_q  <= {attr_d, 8'h20};
                                    adv_q   <= 1'b0;
                                    state_q <= WRITE;
                                end
                            end
                            is_lf: begin
                                x_q <= '0;
                                if (!at_bottom) begin
                                    y_q <= y_q + 4'd1;
                                end else begin
                                    top_q   <= top_d;
                                    ce_q    <= 1'b1;
                                    addr_q  <= line_addr;
                                    data_q  <= {attr_d, 8'h20};
                                    col_q   <= '0;
                                    state_q <= CLR_LINE;
                                end
                            end
                            is_ff: begin
                                ce_q    <= 1'b1;
                                addr_q  <= '0;
                                data_q  <= {attr_d, 8'h20};
                                state_q <= CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    ce_q    <= 1'b0;
                    state_q <= IDLE;
                    if (adv_q) begin
                        if (x_q == 6'(COLS - 1)) begin
                            x_q <= '0;
                            if (!at_bottom) begin
                                y_q <= y_q + 4'd1;
                            end else begin
                                top_q   <= top_d;
                                ce_q    <= 1'b1;
                                addr_q  <= line_addr;
                                data_q  <= {attr_d, 8'h20};
                                col_q   <= '0;
                                state_q <= CLR_LINE;
                            end
                        end else begin
                            x_q <= x_q + 6'd1;
                        end
                    end
                end
                CLR_LINE: begin
                    if (col_q == 6'(COLS - 1)) begin
                        ce_q    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        col_q  <= col_q + 6'd1;
                        addr_q <= addr_q + 12'd1;
                        data_q <= {attr_d, 8'h20};
                    end
                end
                CLR_ALL: begin
                    if (addr_q == 12'(COLS * ROWS - 1)) begin
                        ce_q    <= 1'b0;
                        x_q     <= '0;
                        y_q     <= '0;
                        top_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        addr_q <= addr_q + 12'd1;
                        data_q <= {attr_d, 8'h20};
                    end
                end
            endcase
        end
    end

    assign in_ready = (state_q == IDLE) && reset;
    assign busy     = (state_q != IDLE);
    assign ram_ce   = ce_q;
    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign cursor_x = x_q;
    assign cursor_y = y_q;
    assign top_row  = top_q;

endmodule

// File: tb/tb_vram_console.sv
// Scoreboarded random bench for vram_console: a cell-level console model
// predicts every VRAM write; a monitor pops and compares on each ram_ce.
module tb_vram_console;

    localparam int COLS = 50;
    localparam int ROWS = 15;
    localparam logic [7:0] DEF_ATTR = 8'h0F;

    logic        clk_pix = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        attr_we;
    logic [7:0]  attr_in;
    logic        ram_ce;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;
    logic [5:0]  cursor_x;
    logic [3:0]  cursor_y;
    logic [3:0]  top_row;
    logic        busy;

    vram_console #(.COLS(COLS), .ROWS(ROWS), .DEF_ATTR(DEF_ATTR)) dut (
        .clk_pix (clk_pix),
        .reset   (reset),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .attr_we (attr_we),
        .attr_in (attr_in),
        .ram_ce  (ram_ce),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .top_row (top_row),
        .busy    (busy)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total  = 0;
    int  passed = 0;

    int         m_x, m_y, m_top;
    logic [7:0] m_attr;
    int         sw_at;
    logic [7:0] sw_attr;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void fail_now(string name);
        total++;
        $display("FAIL %s: got timeout/extra expected event", name);
    endfunction

    function automatic void push(int a, logic [15:0] d);
        wr_t w;
        w.a = 12'(a);
        w.d = d;
        exp_q.push_back(w);
    endfunction

    function automatic void m_newline();
        int bottom;
        if (m_y < ROWS - 1) begin
            m_y++;
        end else begin
            m_top  = (m_top + 1) % ROWS;
            bottom = (m_top + ROWS - 1) % ROWS;
            for (int c = 0; c < COLS; c++)
                push(bottom * COLS + c, {m_attr, 8'h20});
        end
    endfunction

    function automatic void model_byte(logic [7:0] b, bit we,
                                       logic [7:0] a);
        int phys;
        if (we) m_attr = a;
        phys = (m_top + m_y) % ROWS;
        if (b >= 8'h20 && b <= 8'h7E) begin
            push(phys * COLS + m_x, {m_attr, b});
            if (m_x == COLS - 1) begin
                m_x = 0;
                m_newline();
            end else begin
                m_x++;
            end
        end else if (b == 8'h0D) begin
            m_x = 0;
        end else if (b == 8'h08) begin
            if (m_x > 0) begin
                m_x--;
                push(phys * COLS + m_x, {m_attr, 8'h20});
            end
        end else if (b == 8'h0A) begin
            m_x = 0;
            m_newline();
        end else if (b == 8'h0C) begin
            for (int i = 0; i < COLS * ROWS; i++) begin
                if (sw_at >= 0 && i == sw_at) m_attr = sw_attr;
                push(i, {m_attr, 8'h20});
            end
            m_x   = 0;
            m_y   = 0;
            m_top = 0;
            sw_at = -1;
        end
    endfunction

    function automatic void model_reset();
        m_x    = 0;
        m_y    = 0;
        m_top  = 0;
        m_attr = DEF_ATTR;
        sw_at  = -1;
    endfunction

    always @(negedge clk_pix) begin
        if (reset === 1'b1 && ram_ce === 1'b1) begin
            chk("ready_low_on_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e.a));
                chk("wr_data", 32'(ram_data), 32'(e.d));
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit we,
                        input logic [7:0] a);
        int t;
        t = 0;
        @(negedge clk_pix);
        while (!in_ready && t < 3000) begin
            @(negedge clk_pix);
            t++;
        end
        if (!in_ready) begin
            fail_now("send_wait_ready");
        end else begin
            model_byte(b, we, a);
            in_valid = 1'b1;
            in_data  = b;
            attr_we  = we;
            attr_in  = a;
            @(posedge clk_pix);
            #1;
            in_valid = 1'b0;
            attr_we  = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk_pix);
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk_pix);
            t++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_cur();
        chk("cursor_x", 32'(cursor_x), 32'(m_x));
        chk("cursor_y", 32'(cursor_y), 32'(m_y));
        chk("top_row", 32'(top_row), 32'(m_top));
    endtask

    task automatic wait_write(input int addr);
        int t;
        t = 0;
        @(negedge clk_pix);
        while (!(ram_ce && ram_addr == 12'(addr)) && t < 2000) begin
            @(negedge clk_pix);
            t++;
        end
        if (!(ram_ce && ram_addr == 12'(addr))) fail_now("wait_write");
    endtask

    initial begin
        int         cnt;
        int         r;
        logic [7:0] b;
        bit         we;
        logic [7:0] a;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        attr_we  = 1'b0;
        attr_in  = 8'h00;
        model_reset();

        repeat (2) @(negedge clk_pix);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_data", 32'(ram_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_cur();
        reset = 1'b1;
        @(negedge clk_pix);
        chk("ready_after_release", 32'(in_ready), 32'd1);

        send(8'h41, 1'b1, 8'h1F);
        @(negedge clk_pix);
        chk("first_ce", 32'(ram_ce), 32'd1);
        chk("first_addr", 32'(ram_addr), 32'd0);
        chk("first_data", 32'(ram_data), 32'h1F41);
        drain();
        chk("first_cursor_x", 32'(cursor_x), 32'd1);
        chk_cur();

        send(8'h0D, 1'b0, 8'h00);
        for (int i = 0; i < COLS; i++)
            send(8'($urandom_range(32, 126)), 1'b0, 8'h00);
        drain();
        chk("wrap_cursor_y", 32'(cursor_y), 32'd1);
        chk_cur();

        send(8'h0D, 1'b0, 8'h00);
        send(8'h08, 1'b0, 8'h00);
        send(8'h78, 1'b0, 8'h00);
        send(8'h08, 1'b0, 8'h00);
        drain();
        chk_cur();

        while (m_y < ROWS - 1) send(8'h0A, 1'b0, 8'h00);
        drain();
        send(8'h0A, 1'b0, 8'h00);
        drain();
        chk("scroll_top_row", 32'(top_row), 32'd1);
        chk_cur();
        send(8'h42, 1'b0, 8'h00);
        drain();

        repeat (300) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 92) b = 8'h08;
            else if (r < 96) b = 8'($urandom_range(128, 255));
            else if (r < 99) b = 8'($urandom_range(0, 7));
            else             b = 8'h0C;
            we = ($urandom_range(0, 9) == 0);
            a  = 8'($urandom);
            send(b, we, a);
        end
        drain();
        chk_cur();

        send(8'h0C, 1'b0, 8'h00);
        cnt = 0;
        @(negedge clk_pix);
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk_pix);
        end
        chk("ff_busy_cycles", 32'(cnt), 32'(COLS * ROWS));
        drain();
        chk_cur();

        sw_at   = 100;
        sw_attr = 8'h5A;
        send(8'h0C, 1'b0, 8'h00);
        wait_write(99);
        attr_we = 1'b1;
        attr_in = 8'h5A;
        @(posedge clk_pix);
        #1;
        attr_we = 1'b0;
        drain();
        chk_cur();

        send(8'h0C, 1'b0, 8'h00);
        wait_write(300);
        #2;
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("abort_ram_ce", 32'(ram_ce), 32'd0);
        chk("abort_ram_addr", 32'(ram_addr), 32'd0);
        chk("abort_ram_data", 32'(ram_data), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk_cur();
        repeat (2) begin
            @(negedge clk_pix);
            chk("abort_no_ce", 32'(ram_ce), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk_pix);
        chk("abort_ready_after", 32'(in_ready), 32'd1);

        send(8'h5A, 1'b0, 8'h00);
        @(negedge clk_pix);
        chk("post_reset_data", 32'(ram_data), 32'h0F5A);
        drain();
        chk_cur();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
